// File: rtl/axi_strm_pkg.sv
// rtl/axi_strm_pkg.sv - shared FSM state type, AXI encodings and sample width for the stream reader
package axi_strm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } strm_state_t;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B     = 3'b011;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam int SAMPLE_W         = 16;
  localparam int SAMPLES_PER_WORD = 4;

endpackage

// File: rtl/strm_rd_fifo.sv
// rtl/strm_rd_fifo.sv - synchronous showahead word FIFO with single-cycle flush and free-word count
module strm_rd_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [DW-1:0]              wr_data,
  input  logic                       rd_en,
  output logic [DW-1:0]              rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] free_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_wr, do_rd;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_wr = wr_en && (count != CW'(DEPTH));
  assign do_rd = rd_en && (count != '0);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // a write and a read in the same cycle both land; count is unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

  assign rd_data  = mem[rd_ptr];
  assign empty    = (count == '0);
  assign free_cnt = CW'(DEPTH) - count;

endmodule

// File: rtl/axi_strm_reader.sv
// rtl/axi_strm_reader.sv - cyclic-buffer AXI burst reader unpacking 64-bit words into 16-bit samples
// Define STRM_UNDERRUN_CNT_EN to build the saturating underrun counter behind sts_underrun_o.
module axi_strm_reader
  import axi_strm_pkg::*;
#(
  parameter int AXI_AW     = 32,
  parameter int AXI_DW     = 64,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                axi_clk_i,
  input  logic                axi_rst_i,
  input  logic                cfg_en_i,
  input  logic [AXI_AW-1:0]   cfg_start_i,
  input  logic [AXI_AW-1:0]   cfg_end_i,
  output logic [3:0]          axi_arid_o,
  output logic [AXI_AW-1:0]   axi_araddr_o,
  output logic [3:0]          axi_arlen_o,
  output logic [2:0]          axi_arsize_o,
  output logic [1:0]          axi_arburst_o,
  output logic                axi_arvalid_o,
  input  logic                axi_arready_i,
  input  logic [AXI_DW-1:0]   axi_rdata_i,
  input  logic [1:0]          axi_rresp_i,
  input  logic                axi_rlast_i,
  input  logic                axi_rvalid_i,
  output logic                axi_rready_o,
  output logic [SAMPLE_W-1:0] sto_tdata_o,
  output logic                sto_tvalid_o,
  input  logic                sto_tready_i,
  output logic                sts_busy_o,
  output logic                sts_err_o,
  output logic [31:0]         sts_underrun_o
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [AXI_AW-1:0] BURST_BYTES = AXI_AW'(BURST_LEN * (AXI_DW / 8));

  strm_state_t         state, state_nxt;
  logic [AXI_AW-1:0]   addr_ptr, addr_inc;
  logic                ar_pend, ar_hs, start_evt, beat_wr, pop_sample, pop_word, drain;
  logic [1:0]          idx;
  logic [AXI_DW-1:0]   fifo_rd_data;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_free;
  logic [SAMPLE_W-1:0] sample;

  assign axi_arid_o    = 4'h0;
  assign axi_arlen_o   = 4'(BURST_LEN - 1);
  assign axi_arsize_o  = AXI_SIZE_8B;
  assign axi_arburst_o = AXI_BURST_INCR;
  assign axi_araddr_o  = addr_ptr;
  assign sts_busy_o    = (state != ST_IDLE);

  assign start_evt  = (state == ST_IDLE) && cfg_en_i;
  assign ar_hs      = axi_arvalid_o && axi_arready_i;
  assign beat_wr    = axi_rvalid_i && axi_rready_o;
  assign pop_sample = sto_tvalid_o && sto_tready_i;
  assign pop_word   = pop_sample && (idx == 2'd3);
  assign addr_inc   = addr_ptr + BURST_BYTES;

  always_ff @(posedge axi_clk_i or posedge axi_rst_i) begin
    if (axi_rst_i) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    axi_arvalid_o = 1'b0;
    axi_rready_o  = 1'b0;
    drain         = 1'b0;
    case (state)
      ST_IDLE: if (cfg_en_i) state_nxt = ST_ADDR;
      ST_ADDR: begin
        // once raised, ar_pend keeps arvalid up even if cfg_en_i falls
        axi_arvalid_o = ar_pend || (cfg_en_i && (fifo_free >= CW'(BURST_LEN)));
        if (axi_arvalid_o && axi_arready_i) state_nxt = ST_DATA;
        else if (!axi_arvalid_o && !cfg_en_i) state_nxt = ST_DRAIN;
      end
      ST_DATA: begin
        axi_rready_o = 1'b1;
        if (axi_rvalid_i && axi_rlast_i) state_nxt = cfg_en_i ? ST_ADDR : ST_DRAIN;
      end
      ST_DRAIN: begin
        drain     = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk_i or posedge axi_rst_i) begin
    if (axi_rst_i) begin
      addr_ptr  <= '0;
      ar_pend   <= 1'b0;
      sts_err_o <= 1'b0;
      idx       <= 2'd0;
    end else begin
      ar_pend <= axi_arvalid_o && !axi_arready_i;
      if (start_evt)  addr_ptr <= cfg_start_i;
      else if (ar_hs) addr_ptr <= (addr_inc >= cfg_end_i) ? cfg_start_i : addr_inc;
      if (start_evt) sts_err_o <= 1'b0;
      else if (beat_wr && (axi_rresp_i != AXI_RESP_OKAY)) sts_err_o <= 1'b1;
      if (drain)           idx <= 2'd0;
      else if (pop_sample) idx <= idx + 2'd1;
    end
  end

  strm_rd_fifo #(
    .DW    (AXI_DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (axi_clk_i),
    .rst      (axi_rst_i),
    .flush    (drain),
    .wr_en    (beat_wr),
    .wr_data  (axi_rdata_i),
    .rd_en    (pop_word),
    .rd_data  (fifo_rd_data),
    .empty    (fifo_empty),
    .free_cnt (fifo_free)
  );

  always_comb begin
    sample = fifo_rd_data[15:0];
    case (idx)
      2'd1:    sample = fifo_rd_data[31:16];
      2'd2:    sample = fifo_rd_data[47:32];
      2'd3:    sample = fifo_rd_data[63:48];
      default: sample = fifo_rd_data[15:0];
    endcase
  end

  // tdata is zeroed while idle so nothing stale leaks out after reset or drain
  assign sto_tvalid_o = (state != ST_DRAIN) && !fifo_empty;
  assign sto_tdata_o  = sto_tvalid_o ? sample : '0;

`ifdef STRM_UNDERRUN_CNT_EN
  logic [31:0] underrun_cnt;

  always_ff @(posedge axi_clk_i or posedge axi_rst_i) begin
    if (axi_rst_i) underrun_cnt <= '0;
    else if (start_evt) underrun_cnt <= '0;
    else if (cfg_en_i && (state != ST_IDLE) && sto_tready_i && !sto_tvalid_o &&
             (underrun_cnt != 32'hFFFF_FFFF))
      underrun_cnt <= underrun_cnt + 32'd1;
  end

  assign sts_underrun_o = underrun_cnt;
`else
  assign sts_underrun_o = 32'd0;
`endif

endmodule

// File: tb/tb_axi_strm_reader.sv
// tb/tb_axi_strm_reader.sv - self-checking bench for axi_strm_reader with AXI slave model and sample scoreboard
module tb_axi_strm_reader;
  localparam int DEPTH = 32;
  localparam int BLEN  = 16;

  logic        clk, rst, en, arvalid, arready, rlast, rvalid, rready, tvalid, tready, busy, err;
  logic [31:0] cfg_start, cfg_end, araddr, underrun;
  logic [3:0]  arid, arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp;
  logic [63:0] rdata;
  logic [15:0] tdata;

  int checks = 0, errors = 0, cyc = 0;
  int occ = 0, sub = 0, wseq = 0, rd_delay = 0, beat_idx = 0, beats_acc = 0, first_acc = -1;
  logic        err_arm = 0, in_burst = 0, stall_prev = 0;
  logic [15:0] data_prev = '0;
  logic [31:0] ar_log [$];
  logic [15:0] exp_q [$];

  axi_strm_reader dut (
    .axi_clk_i(clk), .axi_rst_i(rst), .cfg_en_i(en), .cfg_start_i(cfg_start), .cfg_end_i(cfg_end),
    .axi_arid_o(arid), .axi_araddr_o(araddr), .axi_arlen_o(arlen), .axi_arsize_o(arsize),
    .axi_arburst_o(arburst), .axi_arvalid_o(arvalid), .axi_arready_i(arready),
    .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rlast_i(rlast), .axi_rvalid_i(rvalid),
    .axi_rready_o(rready), .sto_tdata_o(tdata), .sto_tvalid_o(tvalid), .sto_tready_i(tready),
    .sts_busy_o(busy), .sts_err_o(err), .sts_underrun_o(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mkword(input int w);
    return {16'(w*4+4), 16'(w*4+3), 16'(w*4+2), 16'(w*4+1)};
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 500);
    chk(name, 64'(busy), 0);
  endtask

  // AXI read slave: arready always high, BLEN beats per burst after rd_delay idle cycles
  initial begin : slave
    arready = 1'b1; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
    forever begin
      @(negedge clk);
      if (arvalid && !rst) begin
        chk("ar_free_space", 64'((DEPTH - occ) >= BLEN), 1);
        ar_log.push_back(araddr);
        @(posedge clk); #1;
        in_burst = 1'b1; beats_acc = 0;
        repeat (rd_delay) begin @(posedge clk); #1; end
        for (int b = 0; b < BLEN; b++) begin
          if (rst) break;
          rvalid = 1'b1; rlast = (b == BLEN - 1); rdata = mkword(wseq);
          rresp = (err_arm && b == 5) ? 2'b10 : 2'b00;
          for (int k = 0; k < 4; k++) exp_q.push_back(16'(wseq*4 + k + 1));
          wseq++; beat_idx = b;
          @(negedge clk);
          if (!rst) begin
            chk("rready_in_burst", 64'(rready), 1);
            occ++; beats_acc++;
            if (first_acc < 0) first_acc = cyc;
          end
          @(posedge clk); #1;
        end
        err_arm = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; in_burst = 1'b0;
      end
    end
  end

  // sample monitor: scoreboard compare, stall stability, word occupancy model
  initial begin : monitor
    forever begin
      @(negedge clk); #1;
      if (rst || !busy) begin
        exp_q.delete(); occ = 0; sub = 0; stall_prev = 1'b0;
      end else begin
        if (stall_prev && en) begin
          chk("stall_tvalid", 64'(tvalid), 1);
          chk("stall_tdata", 64'(tdata), 64'(data_prev));
        end
        if (tvalid && tready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sample_unexpected actual=%0h required=none", tdata);
          end else chk("sample", 64'(tdata), 64'(exp_q.pop_front()));
          sub++;
          if (sub == 4) begin sub = 0; occ--; end
        end
        stall_prev = tvalid && !tready;
        data_prev  = tdata;
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] start;
    logic [31:0] stop;
    logic [31:0] a0, a1, a2;
  } ar_vec_t;

  initial begin : main
    ar_vec_t vecs [3];
    int n, model;
    vecs[0] = '{32'h1000_0000, 32'h1000_0100, 32'h1000_0000, 32'h1000_0080, 32'h1000_0000};
    vecs[1] = '{32'h2000_0000, 32'h2000_0180, 32'h2000_0000, 32'h2000_0080, 32'h2000_0100};
    vecs[2] = '{32'h0000_0080, 32'h0000_0100, 32'h0000_0080, 32'h0000_0080, 32'h0000_0080};

    rst = 1'b1; en = 1'b0; tready = 1'b1; cfg_start = 32'h1000_0000; cfg_end = 32'h1000_0100;
    repeat (3) @(negedge clk);
    chk("rst_arvalid", 64'(arvalid), 0);
    chk("rst_rready", 64'(rready), 0);
    chk("rst_tvalid", 64'(tvalid), 0);
    chk("rst_tdata", 64'(tdata), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_underrun", 64'(underrun), 0);
    chk("rst_araddr", 64'(araddr), 0);
    chk("rst_arid", 64'(arid), 0);
    chk("rst_arlen", 64'(arlen), 64'hF);
    chk("rst_arsize", 64'(arsize), 64'h3);
    chk("rst_arburst", 64'(arburst), 64'h1);
    @(posedge clk); #1 rst = 1'b0;

    // address sequence and wrap, tready held high
    for (int i = 0; i < 3; i++) begin
      ar_log.delete();
      @(posedge clk); #1;
      cfg_start = vecs[i].start; cfg_end = vecs[i].stop; en = 1'b1;
      n = 0;
      while (ar_log.size() < 3 && n < 2000) begin @(negedge clk); n++; end
      chk("vec_ar_count", 64'(ar_log.size() >= 3), 1);
      @(posedge clk); #1 en = 1'b0;
      wait_idle("vec_idle");
      if (ar_log.size() >= 3) begin
        chk("vec_addr0", 64'(ar_log[0]), 64'(vecs[i].a0));
        chk("vec_addr1", 64'(ar_log[1]), 64'(vecs[i].a1));
        chk("vec_addr2", 64'(ar_log[2]), 64'(vecs[i].a2));
      end
    end

    // unpack order, tvalid latency, tdata hold under backpressure
    ar_log.delete(); wseq = 0; first_acc = -1;
    cfg_start = 32'h1000_0000; cfg_end = 32'h1000_0100;
    @(posedge clk); #1 tready = 1'b0; en = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!tvalid && n < 100);
    chk("first_tvalid", 64'(tvalid), 1);
    chk("tvalid_latency", 64'((cyc - first_acc) <= 2), 1);
    chk("first_sample", 64'(tdata), 64'h0001);
    repeat (5) begin
      @(negedge clk);
      chk("hold_tvalid", 64'(tvalid), 1);
      chk("hold_tdata", 64'(tdata), 64'h0001);
    end
    @(posedge clk); #1 tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("unpack_order", 64'(tdata), 64'(k + 1));
    end
    @(posedge clk); #1 tready = 1'b0;

    // FIFO full: no AR once free space < BLEN
    repeat (300) @(negedge clk);
    chk("full_ar_count", 64'(ar_log.size()), 2);
    chk("full_arvalid", 64'(arvalid), 0);
    chk("full_tvalid", 64'(tvalid), 1);
    @(posedge clk); #1 en = 1'b0;
    wait_idle("full_idle");
    chk("full_drain_tvalid", 64'(tvalid), 0);

    // enable dropped on beat 3 of the first burst
    ar_log.delete();
    @(posedge clk); #1 tready = 1'b1; en = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(in_burst && beat_idx == 1) && n < 200);
    @(posedge clk); #1 en = 1'b0;
    wait_idle("drop_idle");
    chk("drop_beats", 64'(beats_acc), 16);
    chk("drop_tvalid", 64'(tvalid), 0);
    repeat (20) @(negedge clk);
    chk("drop_ar_count", 64'(ar_log.size()), 1);

    // response error is sticky until the next enable
    ar_log.delete(); err_arm = 1'b1;
    @(posedge clk); #1 en = 1'b1;
    n = 0;
    while (ar_log.size() < 2 && n < 1000) begin @(negedge clk); n++; end
    chk("err_stream_continues", 64'(ar_log.size() >= 2), 1);
    chk("err_set", 64'(err), 1);
    @(posedge clk); #1 en = 1'b0;
    wait_idle("err_idle");
    chk("err_sticky", 64'(err), 1);
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("err_cleared", 64'(err), 0);
    @(posedge clk); #1 en = 1'b0;
    wait_idle("err_idle2");

    // starved output while the slave delays rvalid
    model = 0; rd_delay = 10;
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
`ifdef STRM_UNDERRUN_CNT_EN
      chk("underrun_cnt", 64'(underrun), 64'(model));
`else
      chk("underrun_zero", 64'(underrun), 0);
`endif
      if (en && busy && tready && !tvalid) model++;
    end
`ifdef STRM_UNDERRUN_CNT_EN
    chk("underrun_starved", 64'(model >= 10), 1);
`endif
    @(posedge clk); #1 en = 1'b0; rd_delay = 0;
    wait_idle("underrun_idle");

    // reset in the middle of a burst
    @(posedge clk); #1 en = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(in_burst && beat_idx == 5) && n < 200);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 0);
    chk("midrst_rready", 64'(rready), 0);
    chk("midrst_arvalid", 64'(arvalid), 0);
    chk("midrst_tvalid", 64'(tvalid), 0);
    en = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("postrst_busy", 64'(busy), 0);
    chk("postrst_tvalid", 64'(tvalid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
